// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, small-sigma helpers and the schedule FSM state type.
package sha256_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 512;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // s0(x) = rotr7 ^ rotr18 ^ shr3
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // s1(x) = rotr17 ^ rotr19 ^ shr10
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_expand2.sv
// Computes the two next schedule words from the current 16-word window.
// Both words read only the current window, so there is no intra-cycle chain.
module sha256_w_expand2
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] i_w0,
  input  logic [WORD_W-1:0] i_w1,
  input  logic [WORD_W-1:0] i_w2,
  input  logic [WORD_W-1:0] i_w9,
  input  logic [WORD_W-1:0] i_w10,
  input  logic [WORD_W-1:0] i_w14,
  input  logic [WORD_W-1:0] i_w15,
  output logic [WORD_W-1:0] o_w14,
  output logic [WORD_W-1:0] o_w15
);

  // New words W[t+16] and W[t+17], all sums mod 2^32
  always_comb begin
    o_w14 = sig1(i_w14) + i_w9 + sig0(i_w1) + i_w0;
    o_w15 = sig1(i_w15) + i_w10 + sig0(i_w2) + i_w1;
  end

endmodule

// File: rtl/sha256_msg_sched2.sv
// Two-rounds-per-cycle SHA-256 message schedule feeding the compression bank.
// The window is kept as a 512-bit vector with word 0 in the top bits, matching
// blk_data, so a shift-by-two-words is a 64-bit left shift.
module sha256_msg_sched2
  import sha256_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned PAIRS     = 32,
  parameter bit          ZERO_IDLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [BLK_W-1:0]  blk_data,
  output logic [WORD_W-1:0] w_i1,
  output logic [WORD_W-1:0] k_i1,
  output logic [WORD_W-1:0] w_i2,
  output logic [WORD_W-1:0] k_i2,
  output logic              sel,
  output logic              rdy_o,
  output logic              hash_vld,
  output logic              busy,
  output logic [4:0]        pair_idx
);

  sched_state_t      r_state, w_state_nxt;
  logic [BLK_W-1:0]  r_win;
  logic [4:0]        r_pair;
  logic [WORD_W-1:0] r_hold_w1, r_hold_k1, r_hold_w2, r_hold_k2;
  logic [WORD_W-1:0] w_new14, w_new15;
  logic [WORD_W-1:0] w_run_w1, w_run_k1, w_run_w2, w_run_k2;

  sha256_w_expand2 u_expand (
    .i_w0  (r_win[BLK_W-1      -: 32]),
    .i_w1  (r_win[BLK_W-1-32   -: 32]),
    .i_w2  (r_win[BLK_W-1-64   -: 32]),
    .i_w9  (r_win[BLK_W-1-288  -: 32]),
    .i_w10 (r_win[BLK_W-1-320  -: 32]),
    .i_w14 (r_win[BLK_W-1-448  -: 32]),
    .i_w15 (r_win[BLK_W-1-480  -: 32]),
    .o_w14 (w_new14),
    .o_w15 (w_new15)
  );

  // Next-state and control outputs; rdy_o is the same-cycle accept
  always_comb begin
    w_state_nxt = r_state;
    blk_ready   = 1'b0;
    rdy_o       = 1'b0;
    sel         = 1'b0;
    hash_vld    = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        blk_ready = 1'b1;
        rdy_o     = blk_valid;
        if (blk_valid) w_state_nxt = RUN;
      end
      RUN: begin
        sel  = 1'b1;
        busy = 1'b1;
        if (r_pair == 5'(PAIRS - 1)) w_state_nxt = DONE;
      end
      DONE: begin
        hash_vld    = 1'b1;
        busy        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, window and pair counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_pair  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (rdy_o) begin
        r_win  <= blk_data;
        r_pair <= '0;
      end else if (sel) begin
        r_win  <= {r_win[BLK_W-65:0], w_new14, w_new15};
        r_pair <= r_pair + 5'd1;
      end
    end
  end

  // Pair values presented while running; K indexed by 2c and 2c+1
  always_comb begin
    w_run_w1 = r_win[BLK_W-1    -: 32];
    w_run_w2 = r_win[BLK_W-1-32 -: 32];
    w_run_k1 = K_ROM[{r_pair, 1'b0}];
    w_run_k2 = K_ROM[{r_pair, 1'b1}];
  end

  // Last presented pair, used only when outputs hold outside RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_w1 <= '0;
      r_hold_k1 <= '0;
      r_hold_w2 <= '0;
      r_hold_k2 <= '0;
    end else if (sel) begin
      r_hold_w1 <= w_run_w1;
      r_hold_k1 <= w_run_k1;
      r_hold_w2 <= w_run_w2;
      r_hold_k2 <= w_run_k2;
    end
  end

  // Word/constant outputs: live in RUN, zero or held elsewhere
  always_comb begin
    w_i1     = '0;
    k_i1     = '0;
    w_i2     = '0;
    k_i2     = '0;
    pair_idx = '0;
    if (sel) begin
      w_i1     = w_run_w1;
      k_i1     = w_run_k1;
      w_i2     = w_run_w2;
      k_i2     = w_run_k2;
      pair_idx = r_pair;
    end else if (!ZERO_IDLE) begin
      w_i1 = r_hold_w1;
      k_i1 = r_hold_k1;
      w_i2 = r_hold_w2;
      k_i2 = r_hold_k2;
    end
  end

endmodule

// File: doc/sha256_msg_sched2.md
Name: sha256_msg_sched2

Overview:
- Feed side of the two-rounds-per-cycle SHA-256 compression datapath.
- Accepts one padded 512-bit message block and expands it into the 64-word message schedule W[0..63], two words per cycle over 32 cycles.
- Each cycle it presents W[2c], W[2c+1] with round constants K[2c], K[2c+1], and drives the sel/rdy_o controls the compression register bank consumes.
- Signals a one-cycle hash-valid strobe once all 64 rounds are applied.

Parameters:
- WORD_W, 32, schedule word width; only 32 supported.
- PAIRS, 32, round pairs per block; only 32 supported (64 rounds).
- ZERO_IDLE, 1, when 1, w/k outputs are driven to 0 outside RUN; when 0, they hold their last value.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- blk_valid  in  1  a padded block is offered on blk_data.
- blk_ready  out  1  block can be accepted.
- blk_data  in  512  message block; word 0 = blk_data[511:480], word 15 = blk_data[31:0].
- w_i1  out  32  W[2c].
- k_i1  out  32  K[2c].
- w_i2  out  32  W[2c+1].
- k_i2  out  32  K[2c+1].
- sel  out  1  advance compression registers this cycle.
- rdy_o  out  1  reload compression registers with h0..h7 at this edge.
- hash_vld  out  1  one-cycle strobe; downstream hash_val is final.
- busy  out  1  block in flight (RUN or DONE).
- pair_idx  out  5  current pair index c (0 outside RUN).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low.
- Reset values: state=IDLE, window cleared, pair_idx=0. Outputs: blk_ready=1, sel=0, rdy_o=0, hash_vld=0, busy=0, w/k=0.
- Reset mid-block aborts the block; the next accept starts cleanly.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - blk_ready=1.
  - Accept = blk_valid & blk_ready.
  - rdy_o = accept, combinational and same cycle, so the compression bank reloads h0..h7 on the same edge the window loads.
  - On accept: window[0..15] <= words 0..15, pair_idx <= 0, go RUN.
- RUN (exactly 32 cycles, c = 0..31):
  - sel=1, blk_ready=0, busy=1.
  - w_i1=window[0], w_i2=window[1].
  - k_i1=K[2c], k_i2=K[2c+1], taken from the package ROM indexed by pair_idx.
  - Each edge, the window shifts down by 2: window[i] <= window[i+2] for i=0..13.
  - window[14] <= s1(win[14]) + win[9] + s0(win[1]) + win[0]  (W[t+16]).
  - window[15] <= s1(win[15]) + win[10] + s0(win[2]) + win[1]  (W[t+17]).
  - There is no dependency between the two new words within a cycle; both read only the current window.
  - s0(x) = rotr7 ^ rotr18 ^ shr3; s1(x) = rotr17 ^ rotr19 ^ shr10. All sums are mod 2^32.
  - Words computed in the last 8 cycles are unused and harmless.
  - pair_idx increments; at c=31 go to DONE.
- DONE (1 cycle):
  - sel=0, hash_vld=1, busy=1, blk_ready=0, rdy_o=0. Then go IDLE.
- Latency: accept edge at cycle 0; RUN spans cycles 1..32; hash_vld is high in cycle 33.
- Throughput: one block per 34 cycles.
- In IDLE after DONE, sel=0 and rdy_o=0, so the compression result holds until the next accept.
- blk_valid is ignored outside IDLE; no buffering, and the block is not captured.
- blk_data is sampled only at the accept edge; later changes have no effect.
- rdy_o never asserts together with sel.

Decomposition:
- Package sha256_pkg:
  - localparam logic [31:0] K_ROM[64] (FIPS 180-4 constants).
  - functions sig0/sig1 (small sigmas).
  - typedef enum {IDLE, RUN, DONE} sched_state_t.
  - WORD_W, BLK_W=512.
- One natural sub-module: sha256_w_expand2, the combinational computation of the two new words from the 16-word window.
- FSM, window registers and K lookup live in the top.

Test Plan:
- "abc" block (word0=0x61626380, words1-14=0, word15=0x00000018):
  - Cycle 1: w_i1=0x61626380, k_i1=0x428a2f98, k_i2=0x71374491.
  - c=8: w_i1=W16=0x61626380, w_i2=W17=0x000F0000.
  - Final pair: k_i1=0xbef9a3f7, k_i2=0xc67178f2.
- Integration with the compression bank on the "abc" block: at hash_vld, hash_val=BA7816BF 8F01CFEA 414140DE 5DAE2223 B00361A3 96177A9C B410FF61 F20015AD.
- Handshake timing: blk_valid held high continuously -> two accepts exactly 34 cycles apart. Check rdy_o=1 only in the accept cycles, 32 sel cycles, one hash_vld per block, and blk_ready=0 throughout RUN/DONE.
- Reset mid-RUN: assert rst at c=10 -> outputs return to reset values immediately (asynchronous), with no hash_vld. After release, a new "abc" block produces the correct digest.
- Ignored input: change blk_data during RUN -> schedule and digest are unchanged. Raise blk_valid in DONE -> no accept until IDLE.
- Zero block: all-zero blk_data -> W16..W63 match the reference model. With ZERO_IDLE=1, w/k=0 in IDLE and DONE.
